mips_mc_controller: RTL and testbench

Multi-cycle control unit for the next-generation MIPS core, replacing the single-cycle combinational controller. Sequences each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK states and drives datapath strobes. Supports a variable-latency memory handshake with a timeout fault and a retired-instruction counter. Sits between the instruction register fields (`opcode`, `func`) and the multi-cycle datapath inside `mips`.

---
 rtl/mips_mc_controller.sv | 251 +++++++++++++++++++++++++
 tb/tb_mips_mc_controller.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mc_controller.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback with
// memory-timeout fault and retire counter. Optional mult/mflo support via `MUL_DIV_EN.
module mips_mc_controller #(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned MUL_CYCLES  = 4,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [5:0]       opcode,
   input  logic [5:0]       func,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             mem_we,
   output logic             i_or_d,
   output logic             ir_write,
   output logic             pc_write,
   output logic [1:0]       pc_src,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [3:0]       alu_op,
   output logic             signed_imm,
   output logic [1:0]       reg_dst,
   output logic [1:0]       mem_to_reg,
   output logic             reg_write,
   output logic             hilo_write,
   output logic             instr_done,
   output logic             fault,
   output logic [1:0]       fault_code,
   output logic [CNT_W-1:0] retire_cnt
);

   localparam int unsigned CYC_MAX = (MEM_TIMEOUT > MUL_CYCLES) ? MEM_TIMEOUT : MUL_CYCLES;
   localparam int unsigned CYC_W   = $clog2(CYC_MAX + 1);

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_AND = 4'd2;
   localparam logic [3:0] OP_OR  = 4'd3;
   localparam logic [3:0] OP_SLT = 4'd4;
   localparam logic [3:0] OP_LUI = 4'd5;
`ifdef MUL_DIV_EN
   localparam logic [3:0] OP_MUL = 4'd6;
`endif

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_EX_R, S_EX_I, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR,
      S_ALU_WB, S_BRANCH, S_JUMP, S_JAL, S_JR,
`ifdef MUL_DIV_EN
      S_MULT,
`endif
      S_FAULT
   } state_t;

   state_t           state_q, state_d;
   logic [CYC_W-1:0] cyc_q, cyc_d;
   logic [CNT_W-1:0] retire_q, retire_d;
   logic [1:0]       fault_code_q, fault_code_d;
   logic             tmo_hit;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= S_FETCH;
         cyc_q        <= '0;
         retire_q     <= '0;
         fault_code_q <= 2'd0;
      end else begin
         state_q      <= state_d;
         cyc_q        <= cyc_d;
         retire_q     <= retire_d;
         fault_code_q <= fault_code_d;
      end
   end

   assign tmo_hit    = (cyc_q == CYC_W'(MEM_TIMEOUT - 1));
   assign fault      = (state_q == S_FAULT);
   assign fault_code = fault_code_q;
   assign retire_cnt = retire_q;

   // Next-state and strobe decode; strobes are forced low while reset is asserted.
   always_comb begin
      state_d      = state_q;
      fault_code_d = fault_code_q;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      i_or_d       = 1'b0;
      ir_write     = 1'b0;
      pc_write     = 1'b0;
      pc_src       = 2'd0;
      alu_src_a    = 1'b0;
      alu_src_b    = 2'd0;
      alu_op       = OP_ADD;
      signed_imm   = 1'b0;
      reg_dst      = 2'd0;
      mem_to_reg   = 2'd0;
      reg_write    = 1'b0;
      hilo_write   = 1'b0;
      instr_done   = 1'b0;
      if (rst) begin
         case (state_q)
            S_FETCH: begin
               mem_req   = 1'b1;
               alu_src_b = 2'd1;
               if (mem_ready) begin
                  ir_write = 1'b1;
                  pc_write = 1'b1;
                  state_d  = S_DECODE;
               end else if (tmo_hit) begin
                  state_d      = S_FAULT;
                  fault_code_d = 2'd2;
               end
            end
            S_DECODE: begin
               alu_src_b    = 2'd3;
               state_d      = S_FAULT;
               fault_code_d = 2'd1;
               case (opcode)
                  6'h00: begin
                     case (func)
                        6'h20, 6'h22, 6'h24, 6'h25, 6'h2A: state_d = S_EX_R;
                        6'h08: state_d = S_JR;
`ifdef MUL_DIV_EN
                        6'h18: state_d = S_MULT;
                        6'h12: state_d = S_ALU_WB;
`endif
                        default: state_d = S_FAULT;
                     endcase
                  end
                  6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0F: state_d = S_EX_I;
                  6'h23, 6'h2B: state_d = S_MEM_ADDR;
                  6'h04, 6'h05: state_d = S_BRANCH;
                  6'h02:        state_d = S_JUMP;
                  6'h03:        state_d = S_JAL;
                  default:      state_d = S_FAULT;
               endcase
               if (state_d != S_FAULT) fault_code_d = fault_code_q;
            end
            S_EX_R: begin
               alu_src_a = 1'b1;
               case (func)
                  6'h22:   alu_op = OP_SUB;
                  6'h24:   alu_op = OP_AND;
                  6'h25:   alu_op = OP_OR;
                  6'h2A:   alu_op = OP_SLT;
                  default: alu_op = OP_ADD;
               endcase
               state_d = S_ALU_WB;
            end
            S_EX_I: begin
               alu_src_a  = 1'b1;
               alu_src_b  = 2'd2;
               signed_imm = (opcode == 6'h08) || (opcode == 6'h09) || (opcode == 6'h0A);
               case (opcode)
                  6'h0A:   alu_op = OP_SLT;
                  6'h0C:   alu_op = OP_AND;
                  6'h0D:   alu_op = OP_OR;
                  6'h0F:   alu_op = OP_LUI;
                  default: alu_op = OP_ADD;
               endcase
               state_d = S_ALU_WB;
            end
            S_ALU_WB: begin
               reg_write  = 1'b1;
               instr_done = 1'b1;
               reg_dst    = (opcode == 6'h00) ? 2'd1 : 2'd0;
`ifdef MUL_DIV_EN
               if (opcode == 6'h00 && func == 6'h12) mem_to_reg = 2'd3;
`endif
               state_d = S_FETCH;
            end
            S_MEM_ADDR: begin
               alu_src_a  = 1'b1;
               alu_src_b  = 2'd2;
               signed_imm = 1'b1;
               state_d    = (opcode == 6'h23) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
               mem_req = 1'b1;
               i_or_d  = 1'b1;
               if (mem_ready) begin
                  state_d = S_MEM_WB;
               end else if (tmo_hit) begin
                  state_d      = S_FAULT;
                  fault_code_d = 2'd2;
               end
            end
            S_MEM_WB: begin
               reg_write  = 1'b1;
               mem_to_reg = 2'd1;
               instr_done = 1'b1;
               state_d    = S_FETCH;
            end
            S_MEM_WR: begin
               mem_req = 1'b1;
               mem_we  = 1'b1;
               i_or_d  = 1'b1;
               if (mem_ready) begin
                  instr_done = 1'b1;
                  state_d    = S_FETCH;
               end else if (tmo_hit) begin
                  state_d      = S_FAULT;
                  fault_code_d = 2'd2;
               end
            end
            S_BRANCH: begin
               alu_src_a  = 1'b1;
               alu_op     = OP_SUB;
               pc_src     = 2'd1;
               pc_write   = (opcode == 6'h04) ? zero : !zero;
               instr_done = 1'b1;
               state_d    = S_FETCH;
            end
            S_JUMP, S_JAL: begin
               pc_write   = 1'b1;
               pc_src     = 2'd2;
               instr_done = 1'b1;
               if (state_q == S_JAL) begin
                  reg_write  = 1'b1;
                  reg_dst    = 2'd2;
                  mem_to_reg = 2'd2;
               end
               state_d = S_FETCH;
            end
            S_JR: begin
               pc_write   = 1'b1;
               pc_src     = 2'd3;
               instr_done = 1'b1;
               state_d    = S_FETCH;
            end
`ifdef MUL_DIV_EN
            S_MULT: begin
               alu_src_a = 1'b1;
               alu_op    = OP_MUL;
               if (cyc_q == CYC_W'(MUL_CYCLES - 1)) begin
                  hilo_write = 1'b1;
                  instr_done = 1'b1;
                  state_d    = S_FETCH;
               end
            end
`endif
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_FETCH;
         endcase
      end
      // Cycles spent in the current state; restarts whenever the state changes.
      cyc_d    = (state_d == state_q && state_q != S_FAULT) ? cyc_q + CYC_W'(1) : '0;
      retire_d = instr_done ? retire_q + CNT_W'(1) : retire_q;
   end

endmodule

// File: tb/tb_mips_mc_controller.sv
// Directed bench for mips_mc_controller with default parameters (MEM_TIMEOUT=16, MUL_CYCLES=4).
module tb_mips_mc_controller;
   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  opcode, func;
   logic        zero, mem_ready;
   logic        mem_req, mem_we, i_or_d, ir_write, pc_write;
   logic [1:0]  pc_src, alu_src_b, reg_dst, mem_to_reg, fault_code;
   logic        alu_src_a, signed_imm, reg_write, hilo_write, instr_done, fault;
   logic [3:0]  alu_op;
   logic [31:0] retire_cnt;
   int          total = 0;
   int          bad   = 0;
   int          done_seen = 0;

   mips_mc_controller dut (
      .clk(clk), .rst(rst), .opcode(opcode), .func(func), .zero(zero), .mem_ready(mem_ready),
      .mem_req(mem_req), .mem_we(mem_we), .i_or_d(i_or_d), .ir_write(ir_write),
      .pc_write(pc_write), .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .alu_op(alu_op), .signed_imm(signed_imm), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
      .reg_write(reg_write), .hilo_write(hilo_write), .instr_done(instr_done), .fault(fault),
      .fault_code(fault_code), .retire_cnt(retire_cnt)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (instr_done === 1'b1) done_seen++;

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One zero-wait FETCH cycle loading the given instruction.
   task automatic fetch(input logic [5:0] op, input logic [5:0] fn);
      opcode = op; func = fn; mem_ready = 1'b1;
      #1;
      chk("fetch_ir_write", 32'(ir_write), 32'd1);
      tick();
   endtask

   initial begin
      rst = 1'b0; opcode = 6'h00; func = 6'h20; zero = 1'b0; mem_ready = 1'b1;
      tick();
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_ir_write", 32'(ir_write), 32'd0);
      chk("rst_retire", retire_cnt, 32'd0);
      chk("rst_fault", 32'(fault), 32'd0);
      chk("rst_fault_code", 32'(fault_code), 32'd0);
      rst = 1'b1;

      // add: 4 cycles
      #1;
      chk("add_c1_mem_req", 32'(mem_req), 32'd1);
      chk("add_c1_pc_write", 32'(pc_write), 32'd1);
      chk("add_c1_alu_src_b", 32'(alu_src_b), 32'd1);
      tick();
      chk("add_c2_alu_src_b", 32'(alu_src_b), 32'd3);
      chk("add_c2_ir_write", 32'(ir_write), 32'd0);
      tick();
      chk("add_c3_alu_src_a", 32'(alu_src_a), 32'd1);
      chk("add_c3_alu_op", 32'(alu_op), 32'd0);
      tick();
      chk("add_c4_reg_write", 32'(reg_write), 32'd1);
      chk("add_c4_reg_dst", 32'(reg_dst), 32'd1);
      chk("add_c4_done", 32'(instr_done), 32'd1);
      tick();
      chk("add_retire", retire_cnt, 32'd1);
      chk("add_done_once", 32'(done_seen), 32'd1);

      // lw with 3 wait cycles in FETCH and MEM_RD: 11 cycles
      opcode = 6'h23; mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("lw_fetch_wait_ir", 32'(ir_write), 32'd0);
         tick();
      end
      fetch(6'h23, 6'h00);
      tick();
      chk("lw_addr_src_b", 32'(alu_src_b), 32'd2);
      chk("lw_addr_signed", 32'(signed_imm), 32'd1);
      tick();
      mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("lw_rd_i_or_d", 32'(i_or_d), 32'd1);
         chk("lw_rd_done", 32'(instr_done), 32'd0);
         tick();
      end
      mem_ready = 1'b1;
      tick();
      chk("lw_wb_mem_to_reg", 32'(mem_to_reg), 32'd1);
      chk("lw_wb_reg_dst", 32'(reg_dst), 32'd0);
      chk("lw_wb_done", 32'(instr_done), 32'd1);
      tick();
      chk("lw_retire", retire_cnt, 32'd2);

      // beq then bne, both zero values in the BRANCH cycle
      fetch(6'h04, 6'h00);
      tick();
      zero = 1'b1; #1;
      chk("beq_z1_pc_write", 32'(pc_write), 32'd1);
      chk("beq_pc_src", 32'(pc_src), 32'd1);
      chk("beq_alu_op", 32'(alu_op), 32'd1);
      zero = 1'b0; #1;
      chk("beq_z0_pc_write", 32'(pc_write), 32'd0);
      tick();
      fetch(6'h05, 6'h00);
      tick();
      zero = 1'b1; #1;
      chk("bne_z1_pc_write", 32'(pc_write), 32'd0);
      zero = 1'b0; #1;
      chk("bne_z0_pc_write", 32'(pc_write), 32'd1);
      chk("bne_done", 32'(instr_done), 32'd1);
      tick();

      // jal
      fetch(6'h03, 6'h00);
      tick();
      chk("jal_pc_src", 32'(pc_src), 32'd2);
      chk("jal_reg_dst", 32'(reg_dst), 32'd2);
      chk("jal_mem_to_reg", 32'(mem_to_reg), 32'd2);
      chk("jal_reg_write", 32'(reg_write), 32'd1);
      tick();

      // jr
      fetch(6'h00, 6'h08);
      tick();
      chk("jr_pc_src", 32'(pc_src), 32'd3);
      chk("jr_pc_write", 32'(pc_write), 32'd1);
      tick();

      // sw with one wait cycle
      fetch(6'h2B, 6'h00);
      tick();
      tick();
      mem_ready = 1'b0; #1;
      chk("sw_mem_we", 32'(mem_we), 32'd1);
      chk("sw_wait_done", 32'(instr_done), 32'd0);
      tick();
      mem_ready = 1'b1; #1;
      chk("sw_done", 32'(instr_done), 32'd1);
      tick();

      // ori: zero-extended immediate, OR, rt destination
      fetch(6'h0D, 6'h00);
      tick();
      chk("ori_src_b", 32'(alu_src_b), 32'd2);
      chk("ori_signed", 32'(signed_imm), 32'd0);
      chk("ori_alu_op", 32'(alu_op), 32'd3);
      tick();
      chk("ori_reg_dst", 32'(reg_dst), 32'd0);
      tick();
      chk("retire_after_8", retire_cnt, 32'd8);
      chk("done_after_8", 32'(done_seen), 32'd8);

      // mem_ready on the 16th wait cycle beats the timeout; then illegal opcode
      opcode = 6'h3F; mem_ready = 1'b0;
      for (int i = 0; i < 15; i++) tick();
      mem_ready = 1'b1; #1;
      chk("tmo_edge_ir_write", 32'(ir_write), 32'd1);
      tick();
      chk("tmo_edge_decode", 32'(alu_src_b), 32'd3);
      chk("tmo_edge_no_fault", 32'(fault), 32'd0);
      tick();
      chk("illegal_fault", 32'(fault), 32'd1);
      chk("illegal_code", 32'(fault_code), 32'd1);
      tick();
      chk("illegal_sticky", 32'(fault_code), 32'd1);
      chk("illegal_mem_req", 32'(mem_req), 32'd0);

      // reset clears fault, then FETCH timeout
      rst = 1'b0;
      tick();
      rst = 1'b1; mem_ready = 1'b0;
      #1;
      chk("rst_clear_fault", 32'(fault), 32'd0);
      chk("rst_clear_code", 32'(fault_code), 32'd0);
      chk("rst_clear_retire", retire_cnt, 32'd0);
      for (int i = 0; i < 16; i++) begin
         chk("tmo_wait_no_fault", 32'(fault), 32'd0);
         tick();
      end
      chk("tmo_fault", 32'(fault), 32'd1);
      chk("tmo_code", 32'(fault_code), 32'd2);
      chk("tmo_mem_req", 32'(mem_req), 32'd0);
      mem_ready = 1'b1;
      tick(); tick();
      chk("tmo_sticky", 32'(fault_code), 32'd2);
      rst = 1'b0;
      tick();
      rst = 1'b1;

      // mult
      fetch(6'h00, 6'h18);
      tick();
`ifdef MUL_DIV_EN
      for (int i = 0; i < 3; i++) begin
         chk("mult_alu_op", 32'(alu_op), 32'd6);
         chk("mult_hilo_early", 32'(hilo_write), 32'd0);
         tick();
      end
      chk("mult_hilo_last", 32'(hilo_write), 32'd1);
      chk("mult_done_last", 32'(instr_done), 32'd1);
      tick();
      chk("mult_back_fetch", 32'(mem_req), 32'd1);
      chk("mult_retire", retire_cnt, 32'd1);
`else
      chk("mult_illegal_fault", 32'(fault), 32'd1);
      chk("mult_illegal_code", 32'(fault_code), 32'd1);
      chk("mult_hilo", 32'(hilo_write), 32'd0);
`endif
      rst = 1'b0;
      tick();
      rst = 1'b1;

      // reset in the final cycle of an add aborts it without instr_done
      fetch(6'h00, 6'h20);
      tick();
      tick();
      rst = 1'b0; #1;
      chk("abort_no_done", 32'(instr_done), 32'd0);
      chk("abort_no_reg_write", 32'(reg_write), 32'd0);
      tick();
      rst = 1'b1; #1;
      chk("abort_retire", retire_cnt, 32'd0);
      chk("abort_fetch", 32'(mem_req), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
